// File: rtl/pulse_gen_nch_pkg.sv
// Shared types and helpers for the N-channel pulse generator.
// Holds channel state encoding, mode values and parameter-derivation functions.
package pulse_gen_nch_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_e;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   function automatic longint def_per(input longint freq_in, input longint freq_out);
      return freq_in / freq_out;
   endfunction

   function automatic int ch_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/pulse_gen_nch_ch.sv
// One pulse channel: shadow/active configuration, two-state FSM and period counter.
// Active config is only refreshed from the shadow at a start, sync or periodic wrap.
module pulse_gen_nch_ch
   import pulse_gen_nch_pkg::*;
#(
   parameter int              CNT_W   = 32,
   parameter logic [CNT_W-1:0] DEF_PER = CNT_W'(10)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic             cfg_mode,
   input  logic             en,
   input  logic             trig,
   input  logic             sync,
   output logic             pulse,
   output logic             busy
);

   function automatic logic [CNT_W-1:0] clamp_per(input logic [CNT_W-1:0] p);
      if (p < CNT_W'(2)) begin
         clamp_per = CNT_W'(2);
      end else begin
         clamp_per = p;
      end
   endfunction

   localparam logic [CNT_W-1:0] DEF_WID = DEF_PER >> 1;

   ch_state_e        state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [CNT_W-1:0] per_r, per_s;
   logic [CNT_W-1:0] wid_r, wid_s;
   logic             mode_r, mode_s;
   logic [CNT_W-1:0] sh_per_r, sh_per_s;
   logic [CNT_W-1:0] sh_wid_r, sh_wid_s;
   logic             sh_mode_r, sh_mode_s;
   logic             pulse_r, pulse_s;
   logic             busy_r;
   logic             load_s;

   // Register all channel state; reset restores the default configuration
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         per_r     <= clamp_per(DEF_PER);
         wid_r     <= DEF_WID;
         mode_r    <= MODE_PERIODIC;
         sh_per_r  <= DEF_PER;
         sh_wid_r  <= DEF_WID;
         sh_mode_r <= MODE_PERIODIC;
         pulse_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         per_r     <= per_s;
         wid_r     <= wid_s;
         mode_r    <= mode_s;
         sh_per_r  <= sh_per_s;
         sh_wid_r  <= sh_wid_s;
         sh_mode_r <= sh_mode_s;
         pulse_r   <= pulse_s;
         busy_r    <= (state_s == ST_RUN);
      end
   end

   // Next-state logic: EN low beats sync, sync beats wrap, wrap beats counting
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pulse_s = 1'b0;
      load_s  = 1'b0;

      if (cfg_we) begin
         sh_per_s  = cfg_period;
         sh_wid_s  = cfg_width;
         sh_mode_s = cfg_mode;
      end else begin
         sh_per_s  = sh_per_r;
         sh_wid_s  = sh_wid_r;
         sh_mode_s = sh_mode_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (en && ((sh_mode_r == MODE_PERIODIC) || trig)) begin
               load_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
               cnt_s   = '0;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_s = ST_IDLE;
               cnt_s   = '0;
            end else if (sync) begin
               load_s = 1'b1;
            end else if (cnt_r == (per_r - CNT_W'(1))) begin
               if (mode_r == MODE_ONESHOT) begin
                  state_s = ST_IDLE;
                  cnt_s   = '0;
               end else begin
                  load_s = 1'b1;
               end
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
               pulse_s = ((cnt_r + CNT_W'(1)) < wid_r);
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
         end
      endcase

      // The old shadow is used here, so a write in the same cycle is deferred
      if (load_s) begin
         state_s = ST_RUN;
         cnt_s   = '0;
         per_s   = clamp_per(sh_per_r);
         wid_s   = sh_wid_r;
         mode_s  = sh_mode_r;
         pulse_s = (sh_wid_r != '0);
      end else begin
         per_s   = per_r;
         wid_s   = wid_r;
         mode_s  = mode_r;
      end
   end

   assign pulse = pulse_r;
   assign busy  = busy_r;

endmodule

// File: rtl/pulse_gen_nch.sv
// N-channel programmable pulse generator top level.
// Decodes the config channel select and instantiates one channel block per output.
module pulse_gen_nch
   import pulse_gen_nch_pkg::*;
#(
   parameter int  FREQ_IN  = 25_000_000,
   parameter int  FREQ_OUT = 1,
   parameter int  N_CH     = 4,
   parameter int  CNT_W    = 32,
   localparam int CH_W     = ch_width(N_CH)
) (
   input  logic             CLK_IN,
   input  logic             RST_IN,
   input  logic             CFG_WE,
   input  logic [CH_W-1:0]  CFG_CH,
   input  logic [CNT_W-1:0] CFG_PERIOD,
   input  logic [CNT_W-1:0] CFG_WIDTH,
   input  logic             CFG_MODE,
   input  logic [N_CH-1:0]  EN_IN,
   input  logic [N_CH-1:0]  TRIG_IN,
   input  logic             SYNC_IN,
   output logic [N_CH-1:0]  PULSE_OUT,
   output logic [N_CH-1:0]  BUSY_OUT
);

   localparam logic [CNT_W-1:0] DEF_PER = CNT_W'(def_per(longint'(FREQ_IN), longint'(FREQ_OUT)));

   // Selects outside 0..N_CH-1 match no channel and are silently dropped
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pulse_gen_nch_ch #(
         .CNT_W   (CNT_W),
         .DEF_PER (DEF_PER)
      ) u_ch (
         .clk        (CLK_IN),
         .rst        (RST_IN),
         .cfg_we     (CFG_WE && (CFG_CH == CH_W'(i))),
         .cfg_period (CFG_PERIOD),
         .cfg_width  (CFG_WIDTH),
         .cfg_mode   (CFG_MODE),
         .en         (EN_IN[i]),
         .trig       (TRIG_IN[i]),
         .sync       (SYNC_IN),
         .pulse      (PULSE_OUT[i]),
         .busy       (BUSY_OUT[i])
      );
   end

endmodule
